// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared MatMul sizing, loader state encoding and frame-length helpers
package matmul_pkg;

    localparam int MM_SIZE = 2;
    localparam int MM_DW   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_CLR,
        WAIT_DONE
    } ld_state_t;

    // Bytes per frame: full matrix followed by the vector.
    function automatic int frame_len(input int size);
        return size * size + size;
    endfunction

    function automatic int idx_width(input int size);
        return (frame_len(size) > 1) ? $clog2(frame_len(size)) : 1;
    endfunction

endpackage

// File: rtl/matmul_loader.sv
// rtl/matmul_loader.sv - byte-stream loader that assembles MatMul operands and sequences start/done
module matmul_loader
    import matmul_pkg::*;
#(
    parameter int SIZE  = MM_SIZE,
    parameter int DW    = MM_DW,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DW-1:0]                    in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             abort,
    output logic [SIZE-1:0][SIZE-1:0][DW-1:0] mm_mtx,
    output logic [SIZE-1:0][DW-1:0]          mm_vec,
    output logic                             mm_start,
    input  logic                             mm_done,
    output logic                             busy,
    output logic [CNT_W-1:0]                 frame_count
);

    localparam int N  = frame_len(SIZE);
    localparam int IW = idx_width(SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    ld_state_t     state;
    ld_state_t     state_next;
    logic [IW-1:0] index;
    logic          take;
    logic          clear_idx;
    logic          frame_done;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; abort overrides every other transition.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mm_start   = 1'b0;
        busy       = 1'b0;
        take       = 1'b0;
        clear_idx  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (abort) begin
                    clear_idx = 1'b1;
                end else if (in_valid) begin
                    take = 1'b1;
                    if (index == LAST_IDX) begin
                        state_next = START;
                    end
                end
            end
            START: begin
                mm_start   = !abort;
                busy       = !abort;
                state_next = abort ? LOAD : WAIT_CLR;
            end
            WAIT_CLR: begin
                busy = !abort;
                if (abort) begin
                    state_next = LOAD;
                end else if (!mm_done) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                busy = !abort;
                if (abort) begin
                    state_next = LOAD;
                end else if (mm_done) begin
                    busy       = 1'b0;
                    frame_done = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte index within the frame; wraps to 0 after the last byte or on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index <= '0;
        end else if (clear_idx) begin
            index <= '0;
        end else if (take) begin
            index <= (index == LAST_IDX) ? '0 : index + IW'(1);
        end
    end

    // Operand registers only change on accepted bytes, so they stay stable while MatMul runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mm_mtx <= '0;
            mm_vec <= '0;
        end else if (take) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (index == IW'(r * SIZE + c)) begin
                        mm_mtx[r][c] <= in_data;
                    end
                end
            end
            for (int v = 0; v < SIZE; v++) begin
                if (index == IW'(SIZE * SIZE + v)) begin
                    mm_vec[v] <= in_data;
                end
            end
        end
    end

    // Completed-frame counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (frame_done) begin
            frame_count <= frame_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
- Upstream feeder for the MatMul engine.
- Accepts a byte stream on a valid/ready interface and assembles one SIZE×SIZE matrix plus one SIZE-element vector, row-major, matrix first.
- Pulses start into MatMul, holds operands stable until MatMul reports done, then accepts the next frame.
- Sits between the host/stream source and MatMul's mtx_in/vec_in/start/done ports.

Parameters:
- SIZE, 2, matrix dimension; must equal MatMul SIZE.
- DW, 8, operand element width; must match MatMul input width.
- CNT_W, 16, width of completed-frame counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  DW  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- abort  in  1  synchronous; discard current frame / stop waiting.
- mm_mtx  out  SIZE×SIZE×DW  matrix to MatMul mtx_in.
- mm_vec  out  SIZE×DW  vector to MatMul vec_in.
- mm_start  out  1  one-cycle start pulse to MatMul.
- mm_done  in  1  MatMul done (level; stays high until next start is taken).
- busy  out  1  frame issued and not yet complete.
- frame_count  out  CNT_W  number of completed frames.

Behaviour:
- Reset values: in_ready=0, mm_start=0, busy=0, frame_count=0, all mm_mtx/mm_vec elements=0, state=IDLE, index=0.
- Index width is clog2(SIZE*SIZE+SIZE); N = SIZE*SIZE+SIZE bytes per frame.
- IDLE -> LOAD unconditionally on the next edge.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid && in_ready at a rising edge.
  - Byte k (k < SIZE*SIZE) is written to mm_mtx[k/SIZE][k%SIZE].
  - Otherwise byte k is written to mm_vec[k-SIZE*SIZE].
  - index increments per handshake.
  - On handshake of byte N-1: index -> 0, state -> START.
  - Bubbles (in_valid=0) stall without side effects.
- START:
  - mm_start=1 for exactly one cycle, the cycle after the last-byte handshake.
  - in_ready=0; busy=1.
  - Next state WAIT_CLR.
- WAIT_CLR:
  - Waits for mm_done=0, which guards against stale done from the previous frame.
  - Next state WAIT_DONE when mm_done=0.
- WAIT_DONE:
  - On mm_done=1: frame_count increments (wraps modulo 2^CNT_W), busy -> 0, state -> LOAD.
- Operand stability:
  - mm_mtx/mm_vec are registers and change only on LOAD handshakes.
  - They are stable from START until return to LOAD.
- Backpressure: in_ready=0 in START/WAIT_CLR/WAIT_DONE/IDLE; no bytes are consumed there.
- abort=1 has priority over every other transition:
  - In LOAD: index -> 0, no write occurs this cycle even if in_valid.
  - In START/WAIT_*: state -> LOAD, busy -> 0, mm_start -> 0, frame_count unchanged.
  - Already-written operand registers are not cleared.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); the frame is lost.
- mm_start is never asserted in two consecutive cycles.

Decomposition:
- Package matmul_pkg holds:
  - the state enum (IDLE, LOAD, START, WAIT_CLR, WAIT_DONE);
  - the frame-length function N(SIZE);
  - the index-width function.
- MatMul shares SIZE/DW through this package.
- Sub-module: none required. A small stream_deserializer (index counter plus row/column decode) is an acceptable split if it improves reuse.

Test Plan:
- Bytes 1,2,3,4,1,2 back-to-back after reset -> mm_mtx={{1,2},{3,4}}, mm_vec={1,2}, one mm_start pulse. With the MatMul model, vec_out={5,11}, frame_count=1, in_ready=1 afterwards.
- Same frame with in_valid bubbles (every other cycle) -> identical operands, start exactly one cycle after the 6th handshake.
- mm_done held 1 from the prior frame while the second frame 5,6,7,8,3,4 is issued -> loader stays busy until done falls then rises. Result {39,53}; frame_count=2.
- in_valid held 1 during WAIT_DONE -> in_ready=0, no index advance, operands unchanged.
- abort after 3 bytes, then full frame 5,6,7,8,3,4 -> mm_mtx={{5,6},{7,8}}, mm_vec={3,4}, frame_count counts only completed frames.
- reset=0 asserted during WAIT_DONE -> busy=0, mm_start=0, frame_count=0, operands 0 without a clock edge. After release, the next frame loads from index 0.
